// File: rtl/reg_arith_exec_unit_pkg.sv
// Shared decode/execute types: the reg_arith opcode kind, the execute-unit FSM states
// and a small opcode classification helper.
package opcode_type;

  typedef enum logic [3:0] {
    rak_add     = 4'd0,
    rak_sub     = 4'd1,
    rak_sll     = 4'd2,
    rak_slt     = 4'd3,
    rak_sltu    = 4'd4,
    rak_xor     = 4'd5,
    rak_srl     = 4'd6,
    rak_sra     = 4'd7,
    rak_or      = 4'd8,
    rak_and     = 4'd9,
    rak_invalid = 4'd15
  } reg_arith_kind_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } exec_state_t;

  localparam int XLEN_DEFAULT = 32;
  localparam int SHAMT_W      = $clog2(XLEN_DEFAULT);

  function automatic logic is_shift(input reg_arith_kind_t kind);
    return (kind == rak_sll) || (kind == rak_srl) || (kind == rak_sra);
  endfunction

endpackage

// File: rtl/reg_arith_exec_unit_if.sv
// Decode-to-execute-to-writeback handshake bundle; master is the decode/writeback side,
// slave is the execute unit.
interface reg_arith_exec_unit_if #(
  parameter int XLEN = 32
);
  import opcode_type::*;

  logic              in_valid;
  logic              in_ready;
  reg_arith_kind_t   in_kind;
  logic [XLEN-1:0]   in_rs1;
  logic [XLEN-1:0]   in_rs2;
  logic [4:0]        in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result;
  logic [4:0]        out_rd;
  logic              out_illegal;
  logic              busy;

  modport master (
    output in_valid, in_kind, in_rs1, in_rs2, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal, busy
  );

  modport slave (
    input  in_valid, in_kind, in_rs1, in_rs2, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal, busy
  );

endinterface

// File: rtl/reg_arith_exec_unit_iter_shifter.sv
// Iterative shifter: loads a value and shift amount, then moves up to STEP bits per step.
// o_done flags that the current step finishes the shift; o_result is that step's output.
module iter_shifter #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic [XLEN-1:0]          i_value,
  input  logic [$clog2(XLEN)-1:0]  i_shamt,
  input  logic                     i_dir_right,
  input  logic                     i_arith,
  input  logic                     i_step,
  output logic                     o_done,
  output logic [XLEN-1:0]          o_result
);
  localparam int SH_W = $clog2(XLEN);
  localparam logic [SH_W-1:0] STEP_V = SH_W'(STEP);

  logic [XLEN-1:0] r_value;
  logic [SH_W-1:0] r_rem;
  logic            r_dir_right;
  logic            r_arith;
  logic [SH_W-1:0] w_amt;
  logic [XLEN-1:0] w_shifted;

  // One step moves by min(STEP, remaining) in the loaded direction
  always_comb begin
    w_amt     = (r_rem <= STEP_V) ? r_rem : STEP_V;
    w_shifted = r_value;
    if (!r_dir_right) begin
      w_shifted = r_value << w_amt;
    end else if (r_arith) begin
      w_shifted = $signed(r_value) >>> w_amt;
    end else begin
      w_shifted = r_value >> w_amt;
    end
  end

  // Working value and remaining-distance counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value     <= {XLEN{1'b0}};
      r_rem       <= {SH_W{1'b0}};
      r_dir_right <= 1'b0;
      r_arith     <= 1'b0;
    end else if (i_load) begin
      r_value     <= i_value;
      r_rem       <= i_shamt;
      r_dir_right <= i_dir_right;
      r_arith     <= i_arith;
    end else if (i_step) begin
      r_value <= w_shifted;
      r_rem   <= r_rem - w_amt;
    end
  end

  assign o_done   = (r_rem <= STEP_V);
  assign o_result = w_shifted;

endmodule

// File: rtl/reg_arith_exec_unit.sv
// Execute unit for reg_arith ops: single-cycle ALU for most kinds, iterative shifter for
// non-zero shifts, registered result held for writeback under valid/ready.
module reg_arith_exec_unit
  import opcode_type::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_arith_exec_unit_if.slave   bus
);
  localparam int SH_W = $clog2(XLEN);

  exec_state_t     r_state;
  exec_state_t     w_state_nxt;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_take_shift;
  logic            w_illegal;
  logic            w_shift_done;
  logic [SH_W-1:0] w_shamt;
  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_shift_result;
  logic [XLEN-1:0] r_out_result;
  logic [4:0]      r_out_rd;
  logic            r_out_illegal;

  assign w_shamt      = bus.in_rs2[SH_W-1:0];
  assign w_in_ready   = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready);
  assign w_accept     = bus.in_valid & w_in_ready;
  assign w_take_shift = w_accept & is_shift(bus.in_kind) & (w_shamt != {SH_W{1'b0}});

  // Single-cycle result; a zero-distance shift simply passes rs1 through
  always_comb begin
    w_alu_result = {XLEN{1'b0}};
    w_illegal    = 1'b0;
    case (bus.in_kind)
      rak_add:  w_alu_result = bus.in_rs1 + bus.in_rs2;
      rak_sub:  w_alu_result = bus.in_rs1 - bus.in_rs2;
      rak_slt:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(bus.in_rs1) < $signed(bus.in_rs2))};
      rak_sltu: w_alu_result = {{(XLEN-1){1'b0}}, (bus.in_rs1 < bus.in_rs2)};
      rak_xor:  w_alu_result = bus.in_rs1 ^ bus.in_rs2;
      rak_or:   w_alu_result = bus.in_rs1 | bus.in_rs2;
      rak_and:  w_alu_result = bus.in_rs1 & bus.in_rs2;
      rak_sll, rak_srl, rak_sra: w_alu_result = bus.in_rs1;
      default: begin
        w_alu_result = {XLEN{1'b0}};
        w_illegal    = 1'b1;
      end
    endcase
  end

  // Next-state logic; S_DONE with out_ready behaves like S_IDLE for back-to-back accepts
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_take_shift ? S_SHIFT : S_DONE;
        end else if ((r_state == S_DONE) && bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_SHIFT: begin
        if (w_shift_done) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register: captured on accept, overwritten by the shifter on its final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_result  <= {XLEN{1'b0}};
      r_out_rd      <= 5'd0;
      r_out_illegal <= 1'b0;
    end else if (w_accept) begin
      r_out_result  <= w_alu_result;
      r_out_rd      <= bus.in_rd;
      r_out_illegal <= w_illegal;
    end else if ((r_state == S_SHIFT) && w_shift_done) begin
      r_out_result <= w_shift_result;
    end
  end

  iter_shifter #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_take_shift),
    .i_value     (bus.in_rs1),
    .i_shamt     (w_shamt),
    .i_dir_right (bus.in_kind != rak_sll),
    .i_arith     (bus.in_kind == rak_sra),
    .i_step      (r_state == S_SHIFT),
    .o_done      (w_shift_done),
    .o_result    (w_shift_result)
  );

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.out_result  = r_out_result;
  assign bus.out_rd      = r_out_rd;
  assign bus.out_illegal = r_out_illegal;

endmodule

// File: tb/tb_reg_arith_exec_unit.sv
// Directed and randomized-handshake bench for reg_arith_exec_unit (XLEN=32, STEP=1).
module tb_reg_arith_exec_unit;
  import opcode_type::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  reg_arith_exec_unit_if #(.XLEN(32)) bus ();

  reg_arith_exec_unit #(
    .XLEN (32),
    .STEP (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input reg_arith_kind_t k, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r, output logic ill);
    logic [4:0] sh;
    sh  = b[4:0];
    ill = 1'b0;
    case (k)
      rak_add:  r = a + b;
      rak_sub:  r = a - b;
      rak_slt:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      rak_sltu: r = (a < b) ? 32'd1 : 32'd0;
      rak_xor:  r = a ^ b;
      rak_or:   r = a | b;
      rak_and:  r = a & b;
      rak_sll:  r = a << sh;
      rak_srl:  r = a >> sh;
      rak_sra:  r = $unsigned($signed(a) >>> sh);
      default: begin
        r   = 32'd0;
        ill = 1'b1;
      end
    endcase
  endfunction

  task automatic do_op(input string tag, input reg_arith_kind_t k, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] er,
                       input logic eill, input int elat);
    int   lat;
    int   guard;
    logic rdy_seen;
    bus.in_kind   = k;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_rd     = rd;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 64) begin
      tick();
      guard++;
    end
    chk({tag, "_in_ready"}, bus.in_ready, 64'd1);
    tick();
    bus.in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 64) begin
      rdy_seen |= bus.in_ready;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_result"}, bus.out_result, {32'd0, er});
    chk({tag, "_rd"}, bus.out_rd, {59'd0, rd});
    chk({tag, "_illegal"}, bus.out_illegal, {63'd0, eill});
    chk({tag, "_ready_in_shift"}, rdy_seen, 64'd0);
    tick();
    chk({tag, "_drained"}, bus.out_valid, 64'd0);
  endtask

  initial begin
    reg_arith_kind_t kinds [11];
    reg_arith_kind_t k;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [4:0]      rd;
    logic [31:0]     er;
    logic            ei;
    logic [31:0]     q_res [$];
    logic [4:0]      q_rd  [$];
    logic            q_ill [$];
    int              issued;
    int              received;
    int              cyc;
    int              seen;
    logic            acc;

    kinds = '{rak_add, rak_sub, rak_sll, rak_slt, rak_sltu, rak_xor,
              rak_srl, rak_sra, rak_or, rak_and, rak_invalid};
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_kind   = rak_add;
    bus.in_rs1    = 32'd0;
    bus.in_rs2    = 32'd0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 64'd0);
    chk("rst_result", bus.out_result, 64'd0);
    chk("rst_rd", bus.out_rd, 64'd0);
    chk("rst_illegal", bus.out_illegal, 64'd0);
    chk("rst_busy", bus.busy, 64'd0);
    rst_n = 1'b1;
    tick();

    do_op("add_wrap", rak_add,  32'hFFFF_FFFF, 32'h0000_0001, 5'd5,  32'h0000_0000, 1'b0, 1);
    do_op("slt",      rak_slt,  32'h8000_0000, 32'h0000_0001, 5'd6,  32'h0000_0001, 1'b0, 1);
    do_op("sltu",     rak_sltu, 32'h8000_0000, 32'h0000_0001, 5'd8,  32'h0000_0000, 1'b0, 1);
    do_op("sub",      rak_sub,  32'h0000_0000, 32'h0000_0001, 5'd10, 32'hFFFF_FFFF, 1'b0, 1);
    do_op("sra3",     rak_sra,  32'h8000_0000, 32'h0000_0023, 5'd11, 32'hF000_0000, 1'b0, 4);
    do_op("sll0",     rak_sll,  32'h1234_5678, 32'h0000_0020, 5'd12, 32'h1234_5678, 1'b0, 1);
    do_op("srl4",     rak_srl,  32'h8000_0000, 32'h0000_0004, 5'd13, 32'h0800_0000, 1'b0, 5);
    do_op("sll31",    rak_sll,  32'h0000_0001, 32'h0000_001F, 5'd14, 32'h8000_0000, 1'b0, 32);
    do_op("xor",      rak_xor,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd15, 32'h0FF0_0FF0, 1'b0, 1);
    do_op("or",       rak_or,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd16, 32'hFFF0_FFF0, 1'b0, 1);
    do_op("and",      rak_and,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd17, 32'hF000_F000, 1'b0, 1);
    do_op("invalid",  rak_invalid, 32'h1234_5678, 32'h0000_0001, 5'd7, 32'h0000_0000, 1'b1, 1);

    // Writeback stall with the next op already waiting
    bus.in_kind   = rak_xor;
    bus.in_rs1    = 32'hF0F0_F0F0;
    bus.in_rs2    = 32'hFF00_FF00;
    bus.in_rd     = 5'd4;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_kind = rak_add;
    bus.in_rs1  = 32'd2;
    bus.in_rs2  = 32'd3;
    bus.in_rd   = 5'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", bus.out_valid, 64'd1);
      chk("stall_in_ready", bus.in_ready, 64'd0);
      chk("stall_result", bus.out_result, 64'h0FF0_0FF0);
      chk("stall_rd", bus.out_rd, 64'd4);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_valid", bus.out_valid, 64'd1);
    chk("b2b_result", bus.out_result, 64'd5);
    chk("b2b_rd", bus.out_rd, 64'd9);
    tick();
    chk("b2b_drained", bus.out_valid, 64'd0);

    // Reset in the middle of a long shift
    bus.in_kind  = rak_sll;
    bus.in_rs1   = 32'h0000_0001;
    bus.in_rs2   = 32'h0000_001F;
    bus.in_rd    = 5'd3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("midshift_busy", bus.busy, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 64'd0);
    chk("midrst_result", bus.out_result, 64'd0);
    chk("midrst_rd", bus.out_rd, 64'd0);
    chk("midrst_busy", bus.busy, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid || bus.busy) seen++;
    end
    chk("postrst_quiet", 64'(seen), 64'd0);
    do_op("postrst_add", rak_add, 32'd7, 32'd8, 5'd1, 32'd15, 1'b0, 1);

    // Random ops with random writeback back-pressure, checked through a scoreboard
    issued   = 0;
    received = 0;
    cyc      = 0;
    k        = rak_add;
    a        = 32'd0;
    b        = 32'd0;
    rd       = 5'd0;
    while ((issued < 20 || received < 20) && cyc < 3000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid && issued < 20) begin
        k  = kinds[$urandom_range(0, 10)];
        a  = $urandom;
        b  = $urandom;
        rd = 5'($urandom_range(0, 31));
        bus.in_kind  = k;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_rd    = rd;
        bus.in_valid = 1'b1;
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q_res.size() == 0) begin
          chk("rnd_spurious", 64'd1, 64'd0);
        end else begin
          chk("rnd_result", bus.out_result, {32'd0, q_res.pop_front()});
          chk("rnd_rd", bus.out_rd, {59'd0, q_rd.pop_front()});
          chk("rnd_illegal", bus.out_illegal, {63'd0, q_ill.pop_front()});
          received++;
        end
      end
      acc = bus.in_valid & bus.in_ready;
      if (acc) begin
        model(k, a, b, er, ei);
        q_res.push_back(er);
        q_rd.push_back(rd);
        q_ill.push_back(ei);
        issued++;
      end
      tick();
      if (acc) bus.in_valid = 1'b0;
      cyc++;
    end
    chk("rnd_received", 64'(received), 64'd20);
    chk("rnd_leftover", 64'(q_res.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
